// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO and level IRQ.
// Rev 1.0
`default_nettype none

module uart_tx #(
  parameter int          DW           = 32,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] BAUD_DIV_RST = 16'd433
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs_i,
  input  logic          we_i,
  input  logic [3:0]    addr_i,
  input  logic [3:0]    mask_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          tx_o,
  output logic          irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic [15:0]   baud_q;
  logic          tx_en_q, irq_en_q;

  state_e        state_q;
  logic [7:0]    shift_q;
  logic [15:0]   div_q, bcnt_q;
  logic [2:0]    bit_q;
  logic          tx_q, irq_q;

  logic wr_d, push_req_d, push_d, pop_d, empty_d, full_d, ovf_set_d, ovf_clr_d, bit_end_d;

  assign wr_d       = cs_i & we_i;
  assign push_req_d = wr_d & (addr_i[3:2] == 2'd0) & mask_i[0];
  assign empty_d    = (count_q == '0);
  assign full_d     = (count_q == CW'(FIFO_DEPTH));
  assign pop_d      = (state_q == S_IDLE) & tx_en_q & ~empty_d;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_d     = push_req_d & (~full_d | pop_d);
  assign ovf_set_d  = push_req_d & full_d & ~pop_d;
  assign ovf_clr_d  = wr_d & (addr_i[3:2] == 2'd1) & mask_i[0] & wdata_i[3];
  assign bit_end_d  = (bcnt_q == div_q);

  always_comb begin
    count_d = count_q;
    case ({push_d, pop_d})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_d) mem_q[wptr_q] <= wdata_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= BAUD_DIV_RST;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (push_d) wptr_q <= wptr_q + PW'(1);
      if (pop_d)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
      if (ovf_set_d)      ovf_q <= 1'b1;
      else if (ovf_clr_d) ovf_q <= 1'b0;
      if (wr_d && addr_i[3:2] == 2'd2) begin
        if (mask_i[0]) baud_q[7:0]  <= wdata_i[7:0];
        if (mask_i[1]) baud_q[15:8] <= wdata_i[15:8];
      end
      if (wr_d && addr_i[3:2] == 2'd3 && mask_i[0]) begin
        tx_en_q  <= wdata_i[0];
        irq_en_q <= wdata_i[1];
      end
    end
  end

  // Divider is latched at frame start so BAUD_DIV writes only affect the next frame.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_q   <= '0;
      bcnt_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= irq_en_q & empty_d & (state_q == S_IDLE);
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop_d) begin
            shift_q <= mem_q[rptr_q];
            div_q   <= baud_q;
            bcnt_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end_d) begin
            bcnt_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            bcnt_q <= bcnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end_d) begin
            bcnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            bcnt_q <= bcnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end_d) begin
            bcnt_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            bcnt_q <= bcnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    if (cs_i) begin
      case (addr_i[3:2])
        2'd1:    rdata_o = DW'({3'(count_q), ovf_q, empty_d, full_d, (state_q != S_IDLE)});
        2'd2:    rdata_o = DW'(baud_q);
        2'd3:    rdata_o = DW'({irq_en_q, tx_en_q});
        default: rdata_o = '0;
      endcase
    end
  end

  assign tx_o  = tx_q;
  assign irq_o = irq_q;

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], mask_i[3:2], wdata_i[DW-1:16]};

endmodule

`default_nettype wire
